mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 196 +++++++++++++++++++
 tb/tb_mem_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory request/grant/rvalid handshake,
// steers store lanes, extracts/extends load data and fills the MEM/WB register.
package mem_stage_pkg;
    typedef enum logic [1:0] {
        MEM_BYTE  = 2'd0,
        MEM_HWORD = 2'd1,
        MEM_WORD  = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic      mem_read;
        logic      mem_write;
        mem_size_t size;
        logic      sign_ext;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_we;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        mem_ctrl_t   mem_ctrl;
        wb_ctrl_t    wb_ctrl;
        logic [31:0] alu_out;
        logic [31:0] read_data2;
        logic [4:0]  inst_rd;
    } ex_mem_regs_t;

    typedef struct packed {
        wb_ctrl_t    wb_ctrl;
        logic [31:0] alu_out;
        logic [31:0] read_mem_data;
        logic [4:0]  inst_rd;
    } mem_wb_regs_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  ex_mem_regs_t      ex_mem_i,
    input  logic              ex_mem_valid_i,
    output logic              stall_o,
    output mem_wb_regs_t      mem_wb_o,
    output logic              mem_wb_valid_o,
    output logic              misaligned_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t       state;
    ex_mem_regs_t txn;
    ex_mem_regs_t cur;
    logic [1:0]   addr_lo;
    logic         is_mem;
    logic         is_read;
    logic         is_misaligned;
    logic         accept_mem;
    logic [31:0]  lane_word;
    logic [31:0]  load_data;

    function automatic mem_wb_regs_t to_wb(input ex_mem_regs_t e, input logic we,
                                           input logic [31:0] rmd);
        mem_wb_regs_t w;
        w.wb_ctrl        = e.wb_ctrl;
        w.wb_ctrl.reg_we = we;
        w.alu_out        = e.alu_out;
        w.read_mem_data  = rmd;
        w.inst_rd        = e.inst_rd;
        return w;
    endfunction

    // Request fields come straight from EX/MEM when accepting, and from the
    // latched copy afterwards so they stay stable until grant.
    always_comb begin
        cur           = (state == IDLE) ? ex_mem_i : txn;
        addr_lo       = cur.alu_out[1:0];
        is_read       = cur.mem_ctrl.mem_read;
        is_mem        = cur.mem_ctrl.mem_read | cur.mem_ctrl.mem_write;
        is_misaligned = ((cur.mem_ctrl.size == MEM_WORD) && (addr_lo != 2'b00)) ||
                        ((cur.mem_ctrl.size == MEM_HWORD) && addr_lo[0]);
        accept_mem    = (state == IDLE) && ex_mem_valid_i && is_mem && !is_misaligned;

        dmem_req_o    = rst_n && (accept_mem || (state == REQ));
        dmem_we_o     = cur.mem_ctrl.mem_write && !cur.mem_ctrl.mem_read;
        dmem_addr_o   = {cur.alu_out[ADDR_W-1:2], 2'b00};
        case (cur.mem_ctrl.size)
            MEM_WORD: begin
                dmem_be_o    = 4'b1111;
                dmem_wdata_o = cur.read_data2;
            end
            MEM_HWORD: begin
                dmem_be_o    = 4'b0011 << addr_lo;
                dmem_wdata_o = {2{cur.read_data2[15:0]}};
            end
            default: begin
                dmem_be_o    = 4'b0001 << addr_lo;
                dmem_wdata_o = {4{cur.read_data2[7:0]}};
            end
        endcase
    end

    // Stall until the completing cycle: write grant or read data return.
    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = accept_mem && !(!is_read && dmem_gnt_i);
            REQ:     stall_o = !(!is_read && dmem_gnt_i);
            WAIT:    stall_o = !dmem_rvalid_i;
            default: stall_o = 1'b0;
        endcase
        stall_o = stall_o && rst_n;
    end

    // Pick the addressed lane of the returned word and extend it to 32 bits.
    always_comb begin
        lane_word = dmem_rdata_i >> {txn.alu_out[1:0], 3'b000};
        case (txn.mem_ctrl.size)
            MEM_BYTE:  load_data = txn.mem_ctrl.sign_ext ? {{24{lane_word[7]}}, lane_word[7:0]}
                                                         : {24'h0, lane_word[7:0]};
            MEM_HWORD: load_data = txn.mem_ctrl.sign_ext ? {{16{lane_word[15]}}, lane_word[15:0]}
                                                         : {16'h0, lane_word[15:0]};
            default:   load_data = dmem_rdata_i;
        endcase
    end

    // Handshake FSM and MEM/WB register; mem_wb_o holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            txn            <= '0;
            mem_wb_o       <= '0;
            mem_wb_valid_o <= 1'b0;
            misaligned_o   <= 1'b0;
        end else begin
            misaligned_o   <= 1'b0;
            mem_wb_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ex_mem_valid_i) begin
                        mem_wb_o.wb_ctrl.reg_we <= 1'b0;
                    end else if (!is_mem) begin
                        mem_wb_o       <= to_wb(ex_mem_i, ex_mem_i.wb_ctrl.reg_we, '0);
                        mem_wb_valid_o <= 1'b1;
                    end else if (is_misaligned) begin
                        mem_wb_o       <= to_wb(ex_mem_i, 1'b0, '0);
                        mem_wb_valid_o <= 1'b1;
                        misaligned_o   <= 1'b1;
                    end else begin
                        txn <= ex_mem_i;
                        if (!dmem_gnt_i) begin
                            state <= REQ;
                        end else if (is_read) begin
                            state <= WAIT;
                        end else begin
                            mem_wb_o       <= to_wb(ex_mem_i, 1'b0, '0);
                            mem_wb_valid_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        if (is_read) begin
                            state <= WAIT;
                        end else begin
                            mem_wb_o       <= to_wb(txn, 1'b0, '0);
                            mem_wb_valid_o <= 1'b1;
                            state          <= IDLE;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        mem_wb_o       <= to_wb(txn, txn.wb_ctrl.reg_we, load_data);
                        mem_wb_valid_o <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected MEM/WB contents,
// a negedge monitor pops and compares whenever mem_wb_valid_o is high.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    ex_mem_regs_t ex_mem_i;
    logic         ex_mem_valid_i;
    logic         stall_o;
    mem_wb_regs_t mem_wb_o;
    logic         mem_wb_valid_o;
    logic         misaligned_o;
    logic         dmem_req_o;
    logic         dmem_we_o;
    logic [31:0]  dmem_addr_o;
    logic [3:0]   dmem_be_o;
    logic [31:0]  dmem_wdata_o;
    logic         dmem_gnt_i;
    logic         dmem_rvalid_i;
    logic [31:0]  dmem_rdata_i;

    int checks   = 0;
    int failures = 0;
    mem_wb_regs_t exp_q[$];
    mem_wb_regs_t mon_e;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_mem_i       (ex_mem_i),
        .ex_mem_valid_i (ex_mem_valid_i),
        .stall_o        (stall_o),
        .mem_wb_o       (mem_wb_o),
        .mem_wb_valid_o (mem_wb_valid_o),
        .misaligned_o   (misaligned_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_be_o      (dmem_be_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    function automatic ex_mem_regs_t mk(input logic rd_, input logic wr_, input mem_size_t sz,
                                        input logic sx, input logic [31:0] addr,
                                        input logic [31:0] rd2, input logic [4:0] rd,
                                        input logic we);
        ex_mem_regs_t e;
        e.mem_ctrl.mem_read    = rd_;
        e.mem_ctrl.mem_write   = wr_;
        e.mem_ctrl.size        = sz;
        e.mem_ctrl.sign_ext    = sx;
        e.wb_ctrl.reg_we       = we;
        e.wb_ctrl.mem_to_reg   = rd_;
        e.alu_out              = addr;
        e.read_data2           = rd2;
        e.inst_rd              = rd;
        return e;
    endfunction

    function automatic mem_wb_regs_t wb(input logic [31:0] alu, input logic [4:0] rd,
                                        input logic we, input logic mtr, input logic [31:0] rmd);
        mem_wb_regs_t w;
        w.wb_ctrl.reg_we     = we;
        w.wb_ctrl.mem_to_reg = mtr;
        w.alu_out            = alu;
        w.read_mem_data      = rmd;
        w.inst_rd            = rd;
        return w;
    endfunction

    // Monitor: every valid MEM/WB output must match the oldest expectation.
    always @(negedge clk) begin
        if (mem_wb_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected: got valid rd=%0d alu=0x%08h expected no output",
                         mem_wb_o.inst_rd, mem_wb_o.alu_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_rd", 32'(mem_wb_o.inst_rd), 32'(mon_e.inst_rd));
                chk("wb_alu_out", mem_wb_o.alu_out, mon_e.alu_out);
                chk("wb_reg_we", 32'(mem_wb_o.wb_ctrl.reg_we), 32'(mon_e.wb_ctrl.reg_we));
                chk("wb_mem_to_reg", 32'(mem_wb_o.wb_ctrl.mem_to_reg), 32'(mon_e.wb_ctrl.mem_to_reg));
                chk("wb_read_mem_data", mem_wb_o.read_mem_data, mon_e.read_mem_data);
            end
        end
    end

    // One memory transaction; EX/MEM stays frozen while stalled.
    task automatic mem_case(input string nm, input ex_mem_regs_t e, input int gnt_dly,
                            input int rv_dly, input logic [31:0] rdata, input mem_wb_regs_t exp,
                            input int exp_req, input int exp_stall, input logic exp_we,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd,
                            input logic [31:0] exp_addr);
        int req_cnt;
        int stall_cnt;
        int last;
        logic is_rd;
        req_cnt   = 0;
        stall_cnt = 0;
        is_rd     = e.mem_ctrl.mem_read;
        last      = is_rd ? gnt_dly + rv_dly : gnt_dly;
        exp_q.push_back(exp);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            ex_mem_i       = e;
            ex_mem_valid_i = 1'b1;
            dmem_gnt_i     = (k == gnt_dly);
            dmem_rvalid_i  = is_rd && (k == last);
            dmem_rdata_i   = (k == last) ? rdata : 32'h0BAD_0BAD;
            #1;
            if (dmem_req_o) req_cnt++;
            if (stall_o) stall_cnt++;
            if (k == 0 || k == gnt_dly) begin
                chk({nm, "_addr"}, dmem_addr_o, exp_addr);
                chk({nm, "_we"}, 32'(dmem_we_o), 32'(exp_we));
                if (exp_we) begin
                    chk({nm, "_be"}, 32'(dmem_be_o), 32'(exp_be));
                    chk({nm, "_wdata"}, dmem_wdata_o, exp_wd);
                end
            end
        end
        chk({nm, "_req_cycles"}, 32'(req_cnt), 32'(exp_req));
        chk({nm, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        @(negedge clk);
        ex_mem_valid_i = 1'b0;
        dmem_gnt_i     = 1'b0;
        dmem_rvalid_i  = 1'b0;
    endtask

    // Single-cycle op: ALU pass-through or misaligned bubble.
    task automatic simple_case(input string nm, input ex_mem_regs_t e, input mem_wb_regs_t exp,
                               input logic exp_mis);
        exp_q.push_back(exp);
        @(negedge clk);
        ex_mem_i       = e;
        ex_mem_valid_i = 1'b1;
        #1;
        chk({nm, "_req"}, 32'(dmem_req_o), 32'd0);
        chk({nm, "_stall"}, 32'(stall_o), 32'd0);
        @(negedge clk);
        ex_mem_valid_i = 1'b0;
        chk({nm, "_misaligned"}, 32'(misaligned_o), 32'(exp_mis));
        @(negedge clk);
        chk({nm, "_misaligned_clear"}, 32'(misaligned_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        ex_mem_i       = '0;
        ex_mem_valid_i = 1'b0;
        dmem_gnt_i     = 1'b0;
        dmem_rvalid_i  = 1'b0;
        dmem_rdata_i   = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(mem_wb_valid_o), 32'd0);
        chk("rst_alu_out", mem_wb_o.alu_out, 32'd0);
        chk("rst_rmd", mem_wb_o.read_mem_data, 32'd0);
        chk("rst_misaligned", 32'(misaligned_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        simple_case("alu", mk(0, 0, MEM_WORD, 0, 32'h1234, 32'h0, 5'd5, 1'b1),
                    wb(32'h1234, 5'd5, 1'b1, 1'b0, 32'h0), 1'b0);

        mem_case("lw", mk(1, 0, MEM_WORD, 0, 32'h100, 32'h0, 5'd7, 1'b1), 2, 2, 32'hDEADBEEF,
                 wb(32'h100, 5'd7, 1'b1, 1'b1, 32'hDEADBEEF), 3, 4, 1'b0, 4'hF, 32'h0, 32'h100);
        mem_case("lb", mk(1, 0, MEM_BYTE, 1, 32'h103, 32'h0, 5'd8, 1'b1), 0, 1, 32'h80FF_FFFF,
                 wb(32'h103, 5'd8, 1'b1, 1'b1, 32'hFFFFFF80), 1, 1, 1'b0, 4'h0, 32'h0, 32'h100);
        mem_case("lbu", mk(1, 0, MEM_BYTE, 0, 32'h103, 32'h0, 5'd9, 1'b1), 0, 1, 32'h80FF_FFFF,
                 wb(32'h103, 5'd9, 1'b1, 1'b1, 32'h00000080), 1, 1, 1'b0, 4'h0, 32'h0, 32'h100);
        mem_case("lh", mk(1, 0, MEM_HWORD, 1, 32'h102, 32'h0, 5'd12, 1'b1), 1, 1, 32'h8001_0000,
                 wb(32'h102, 5'd12, 1'b1, 1'b1, 32'hFFFF8001), 2, 2, 1'b0, 4'h0, 32'h0, 32'h100);
        mem_case("lhu", mk(1, 0, MEM_HWORD, 0, 32'h200, 32'h0, 5'd13, 1'b1), 0, 1, 32'h1234_F00D,
                 wb(32'h200, 5'd13, 1'b1, 1'b1, 32'h0000F00D), 1, 1, 1'b0, 4'h0, 32'h0, 32'h200);
        mem_case("sh", mk(0, 1, MEM_HWORD, 0, 32'h102, 32'h0000ABCD, 5'd3, 1'b1), 0, 0, 32'h0,
                 wb(32'h102, 5'd3, 1'b0, 1'b0, 32'h0), 1, 0, 1'b1, 4'b1100, 32'hABCDABCD, 32'h100);
        mem_case("sb", mk(0, 1, MEM_BYTE, 0, 32'h101, 32'h12345655, 5'd4, 1'b1), 1, 0, 32'h0,
                 wb(32'h101, 5'd4, 1'b0, 1'b0, 32'h0), 2, 1, 1'b1, 4'b0010, 32'h55555555, 32'h100);
        mem_case("sw", mk(0, 1, MEM_WORD, 0, 32'h204, 32'hCAFEF00D, 5'd6, 1'b1), 3, 0, 32'h0,
                 wb(32'h204, 5'd6, 1'b0, 1'b0, 32'h0), 4, 3, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h204);
        mem_case("rdwr", mk(1, 1, MEM_WORD, 0, 32'h300, 32'hFFFFFFFF, 5'd14, 1'b1), 0, 1, 32'h01020304,
                 wb(32'h300, 5'd14, 1'b1, 1'b1, 32'h01020304), 1, 1, 1'b0, 4'h0, 32'h0, 32'h300);

        simple_case("mis_lw", mk(1, 0, MEM_WORD, 0, 32'h101, 32'h0, 5'd10, 1'b1),
                    wb(32'h101, 5'd10, 1'b0, 1'b1, 32'h0), 1'b1);
        simple_case("mis_sh", mk(0, 1, MEM_HWORD, 0, 32'h103, 32'h1111, 5'd11, 1'b1),
                    wb(32'h103, 5'd11, 1'b0, 1'b0, 32'h0), 1'b1);

        // Invalid slot and stray rvalid in IDLE: no output, reg_we cleared.
        @(negedge clk);
        ex_mem_i       = mk(0, 0, MEM_WORD, 0, 32'h55, 32'h0, 5'd15, 1'b1);
        ex_mem_valid_i = 1'b0;
        dmem_rvalid_i  = 1'b1;
        dmem_rdata_i   = 32'h99999999;
        @(negedge clk);
        dmem_rvalid_i  = 1'b0;
        chk("bubble_valid", 32'(mem_wb_valid_o), 32'd0);
        chk("bubble_reg_we", 32'(mem_wb_o.wb_ctrl.reg_we), 32'd0);
        chk("bubble_rmd_held", mem_wb_o.read_mem_data, 32'h0);

        // Reset while in WAIT, then a late rvalid.
        @(negedge clk);
        ex_mem_i       = mk(1, 0, MEM_WORD, 0, 32'h100, 32'h0, 5'd16, 1'b1);
        ex_mem_valid_i = 1'b1;
        dmem_gnt_i     = 1'b1;
        #1;
        chk("rstw_req", 32'(dmem_req_o), 32'd1);
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("rstw_stall_in_reset", 32'(stall_o), 32'd0);
        chk("rstw_req_in_reset", 32'(dmem_req_o), 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        ex_mem_valid_i = 1'b0;
        dmem_rvalid_i  = 1'b1;
        dmem_rdata_i   = 32'h77777777;
        #1;
        chk("rstw_stall_after", 32'(stall_o), 32'd0);
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        chk("rstw_valid", 32'(mem_wb_valid_o), 32'd0);
        chk("rstw_rmd", mem_wb_o.read_mem_data, 32'h0);
        chk("rstw_stall", 32'(stall_o), 32'd0);

        // Stage still accepts work after the abandoned read.
        simple_case("alu2", mk(0, 0, MEM_WORD, 0, 32'hA5A5_0001, 32'h0, 5'd31, 1'b1),
                    wb(32'hA5A5_0001, 5'd31, 1'b1, 1'b0, 32'h0), 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
